i2c_cfg_master: RTL and testbench
=================================

Name: i2c_cfg_master

Overview:
- Single-transaction I2C write master that configures the audio codec over the shared I2C bus.
- Takes a 24-bit word from a software-driven output port: slave address + R/W, register byte, data byte.
- Serialises the word with START/STOP, samples the three ACKs, and raises `end_flag` when done.
- `end_flag` and `ack_err` feed the Avalon input ports that software polls to detect completion.

Parameters:
- `QUARTER_DIV`, default 125: clk cycles per quarter SCL period. 50 MHz / (4 × 125) = 100 kHz SCL.
- `CNT_W`, default 8: width of the quarter-period counter. Must satisfy 2^CNT_W > QUARTER_DIV.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: begin a transaction. Level-sampled; accepted only in IDLE.
- `i2c_data` input 24: {addr_rw[23:16], reg[15:8], data[7:0]}. Captured on accept.
- `busy` output 1: high from accept through the end of STOP.
- `end_flag` output 1: transaction complete. Sticky until the next accepted start.
- `ack_err` output 1: at least one NACK in the last transaction. Sticky like `end_flag`.
- `i2c_sclk` output 1: SCL. Push-pull, idle high.
- `i2c_sdat_oe` output 1: 1 = pull SDA low. External tri-state; idle 0.
- `i2c_sdat_in` input 1: sampled SDA line. Two-flop synchronised internally.

Behaviour:
- **Reset:** state = IDLE. `busy` = 0, `end_flag` = 0, `ack_err` = 0, `i2c_sclk` = 1, `i2c_sdat_oe` = 0, counters = 0. Reset mid-transaction aborts immediately: SCL and SDA are released the next cycle, with no STOP generated.
- **Tick:** the quarter counter runs only outside IDLE. It counts 0..QUARTER_DIV-1, and a `tick` fires on the wrap. Each phase below lasts one quarter, and all state and output changes occur on `tick`.
- **IDLE:** if `start` = 1:
  - latch `i2c_data` into `shreg`;
  - clear `end_flag` and `ack_err`;
  - set `busy` = 1;
  - go to START (same cycle; counter restarts at 0).
- **START:** 2 quarters.
  - q0: SDA low with SCL high (START condition).
  - q1: SCL low.
  - Then byte_idx = 0, bit_idx = 7.
- **BIT:** 4 quarters per bit, MSB first.
  - q0: SDA = `shreg` MSB (oe = ~bit) with SCL low.
  - q1: SCL high.
  - q2: hold.
  - q3: SCL low, shift `shreg` left.
  - After bit_idx 0, go to ACK.
- **ACK:** 4 quarters.
  - q0: release SDA.
  - q1: SCL high.
  - q2: sample the synchronised SDA; a 1 sets `ack_err`.
  - q3: SCL low.
  - If byte_idx = 2, go to STOP; otherwise byte_idx++, bit_idx = 7, go to BIT.
  - A NACK does not abort: all three bytes are always sent.
- **STOP:** 3 quarters.
  - q0: SDA low, SCL low.
  - q1: SCL high.
  - q2: release SDA (STOP condition).
  - Then go to DONE.
- **DONE:** 1 cycle. Set `busy` = 0, `end_flag` = 1; go to IDLE.
- **Timing:** total transaction = 2 + 27×4 + 3 = 113 quarters = 14125 clk cycles at the default. `end_flag` rises exactly 14125 + 1 cycles after the accepting cycle.
- **Start while busy:** ignored. A `start` held high across DONE re-triggers in the first IDLE cycle, clearing `end_flag` one cycle after it rose; this is legal.
- **SCL:** never stretched. `i2c_sdat_in` is used only in ACK.

Optional Feature:
- Macro: `I2C_CFG_RETRY_EN`.
- **Defined:** on a NACK at ACK q3, instead of continuing, go to STOP and then restart the whole transaction from START with the same latched word.
  - Retry counter is 2 bits, up to 3 retries.
  - `ack_err` is set only if the final attempt NACKs.
  - `end_flag` is asserted once, after the final attempt.
- **Undefined:** behaviour exactly as above. No retry logic is synthesised.

Test Plan:
1. Reset for 3 cycles with `start` = 1 → `busy`/`end_flag`/`ack_err` = 0, SCL = 1, oe = 0; no transaction starts until after reset deasserts.
2. `i2c_data` = 0x34_0E_42, slave ACKs all bytes → SCL toggles 27 times at 100 kHz. The bus monitor decodes START, 0x34/A, 0x0E/A, 0x42/A, STOP. `end_flag` = 1 at 14126 cycles; `ack_err` = 0.
3. Same word, slave NACKs the register byte → all 3 bytes are still sent; `ack_err` = 1, `end_flag` = 1. With `I2C_CFG_RETRY_EN`: 4 START conditions are seen before `end_flag`.
4. Pulse `start` at cycle 5000 of a running transaction with a different word → ignored; the bus still carries the original word.
5. Assert `reset` mid-byte-2 → next cycle SCL = 1, oe = 0, `busy` = 0, no STOP. A new start then completes normally.
6. Hold `start` high continuously → back-to-back transactions; `end_flag` high for exactly 1 cycle each time, with 1 IDLE cycle between the STOP and the next START.

Source files
------------

// File: rtl/i2c_cfg_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_master_if
// Purpose  : Software handshake plus I2C pin bundle for i2c_cfg_master.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_cfg_master_if;
  logic        start;
  logic [23:0] i2c_data;
  logic        busy;
  logic        end_flag;
  logic        ack_err;
  logic        i2c_sclk;
  logic        i2c_sdat_oe;
  logic        i2c_sdat_in;

  // master = software / board side, slave = the configuration engine
  modport master (
    output start, i2c_data, i2c_sdat_in,
    input  busy, end_flag, ack_err, i2c_sclk, i2c_sdat_oe
  );

  modport slave (
    input  start, i2c_data, i2c_sdat_in,
    output busy, end_flag, ack_err, i2c_sclk, i2c_sdat_oe
  );
endinterface
`default_nettype wire

// File: rtl/i2c_cfg_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_master
// Purpose  : Single-transaction I2C write master: START, 3 bytes + ACKs, STOP.
//            Optional macro I2C_CFG_RETRY_EN re-runs a NACKed transfer (max 3x).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_master #(
  parameter int QUARTER_DIV = 125,
  parameter int CNT_W       = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  i2c_cfg_master_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(QUARTER_DIV - 1);

  state_t           r_state,    w_state_nxt;
  logic [1:0]       r_q,        w_q_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [2:0]       r_bit_idx,  w_bit_idx_nxt;
  logic [1:0]       r_byte_idx, w_byte_idx_nxt;
  logic [23:0]      r_shreg,    w_shreg_nxt;
  logic             r_sclk,     w_sclk_nxt;
  logic             r_sdat_oe,  w_sdat_oe_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_end_flag, w_end_flag_nxt;
  logic             r_ack_err,  w_ack_err_nxt;
  logic [1:0]       r_sda_sync;
  logic             w_tick;
  logic             w_sda;
`ifdef I2C_CFG_RETRY_EN
  logic [23:0]      r_word,     w_word_nxt;
  logic [1:0]       r_retry,    w_retry_nxt;
  logic             r_nack,     w_nack_nxt;
`endif

  assign w_tick = (r_cnt == C_CNT_LAST);
  assign w_sda  = r_sda_sync[1];

  assign bus.busy        = r_busy;
  assign bus.end_flag    = r_end_flag;
  assign bus.ack_err     = r_ack_err;
  assign bus.i2c_sclk    = r_sclk;
  assign bus.i2c_sdat_oe = r_sdat_oe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shreg    <= '0;
      r_sclk     <= 1'b1;
      r_sdat_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_end_flag <= 1'b0;
      r_ack_err  <= 1'b0;
      r_sda_sync <= 2'b11;
`ifdef I2C_CFG_RETRY_EN
      r_word     <= '0;
      r_retry    <= '0;
      r_nack     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_q        <= w_q_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_shreg    <= w_shreg_nxt;
      r_sclk     <= w_sclk_nxt;
      r_sdat_oe  <= w_sdat_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_end_flag <= w_end_flag_nxt;
      r_ack_err  <= w_ack_err_nxt;
      r_sda_sync <= {r_sda_sync[0], bus.i2c_sdat_in};
`ifdef I2C_CFG_RETRY_EN
      r_word     <= w_word_nxt;
      r_retry    <= w_retry_nxt;
      r_nack     <= w_nack_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_q_nxt        = r_q;
    w_cnt_nxt      = r_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_shreg_nxt    = r_shreg;
    w_busy_nxt     = r_busy;
    w_end_flag_nxt = r_end_flag;
    w_ack_err_nxt  = r_ack_err;
    w_sclk_nxt     = 1'b1;
    w_sdat_oe_nxt  = 1'b0;
`ifdef I2C_CFG_RETRY_EN
    w_word_nxt     = r_word;
    w_retry_nxt    = r_retry;
    w_nack_nxt     = r_nack;
`endif

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.start) begin
          w_shreg_nxt    = bus.i2c_data;
          w_end_flag_nxt = 1'b0;
          w_ack_err_nxt  = 1'b0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_START;
          w_q_nxt        = 2'd0;
`ifdef I2C_CFG_RETRY_EN
          w_word_nxt     = bus.i2c_data;
          w_retry_nxt    = 2'd0;
          w_nack_nxt     = 1'b0;
`endif
        end
      end
      S_DONE: begin
        w_cnt_nxt      = '0;
        w_busy_nxt     = 1'b0;
        w_end_flag_nxt = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          case (r_state)
            S_START: begin
              if (r_q == 2'd1) begin
                w_state_nxt    = S_BIT;
                w_q_nxt        = 2'd0;
                w_bit_idx_nxt  = 3'd7;
                w_byte_idx_nxt = 2'd0;
              end
            end
            S_BIT: begin
              if (r_q == 2'd3) begin
                w_shreg_nxt = {r_shreg[22:0], 1'b0};
                if (r_bit_idx == 3'd0) begin
                  w_state_nxt = S_ACK;
                end else begin
                  w_bit_idx_nxt = r_bit_idx - 3'd1;
                end
              end
            end
            S_ACK: begin
              // SDA is sampled at the end of the second high quarter of SCL
              if (r_q == 2'd2) begin
`ifdef I2C_CFG_RETRY_EN
                w_nack_nxt = r_nack | w_sda;
`else
                w_ack_err_nxt = r_ack_err | w_sda;
`endif
              end
              if (r_q == 2'd3) begin
`ifdef I2C_CFG_RETRY_EN
                if (r_byte_idx == 2'd2 || r_nack) begin
`else
                if (r_byte_idx == 2'd2) begin
`endif
                  w_state_nxt = S_STOP;
                end else begin
                  w_byte_idx_nxt = r_byte_idx + 2'd1;
                  w_bit_idx_nxt  = 3'd7;
                  w_state_nxt    = S_BIT;
                end
              end
            end
            S_STOP: begin
              if (r_q == 2'd2) begin
                w_q_nxt = 2'd0;
`ifdef I2C_CFG_RETRY_EN
                if (r_nack && r_retry != 2'd3) begin
                  w_retry_nxt = r_retry + 2'd1;
                  w_nack_nxt  = 1'b0;
                  w_shreg_nxt = r_word;
                  w_state_nxt = S_START;
                end else begin
                  w_ack_err_nxt = r_nack;
                  w_state_nxt   = S_DONE;
                end
`else
                w_state_nxt = S_DONE;
`endif
              end
            end
            default: begin
              w_state_nxt = S_IDLE;
            end
          endcase
        end
      end
    endcase

    // Pins are a registered decode of the phase being entered: glitch-free
    case (w_state_nxt)
      S_START: begin
        w_sclk_nxt    = (w_q_nxt == 2'd0);
        w_sdat_oe_nxt = 1'b1;
      end
      S_BIT: begin
        w_sclk_nxt    = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
        w_sdat_oe_nxt = ~w_shreg_nxt[23];
      end
      S_ACK: begin
        w_sclk_nxt    = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
        w_sdat_oe_nxt = 1'b0;
      end
      S_STOP: begin
        w_sclk_nxt    = (w_q_nxt != 2'd0);
        w_sdat_oe_nxt = (w_q_nxt != 2'd2);
      end
      default: begin
        w_sclk_nxt    = 1'b1;
        w_sdat_oe_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_cfg_master
// Purpose  : Self-checking bench: I2C bus monitor + ACK/NACK slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_cfg_master;
  localparam int QD        = 10;
  localparam int CW        = 4;
  localparam int C_TIMEOUT = 5000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_cfg_master_if bus();

  i2c_cfg_master #(.QUARTER_DIV(QD), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic       slave_pull = 1'b0;
  logic       sda_line;
  logic [2:0] nack_mask;
  assign sda_line        = ~(bus.i2c_sdat_oe | slave_pull);
  assign bus.i2c_sdat_in = sda_line;

  int         mon_starts  = 0;
  int         mon_stops   = 0;
  int         mon_bitcnt  = 0;
  int         mon_bytecnt = 0;
  logic [7:0] mon_shift   = 8'h00;
  logic [7:0] mon_bytes[$];
  logic       mon_acks[$];
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       scl_now;
  logic       sda_now;

  // Bus monitor and addressed-slave model, evaluated away from the clock edge
  always @(negedge clk) begin
    scl_now = bus.i2c_sclk;
    sda_now = sda_line;
    if (prev_scl && scl_now && prev_sda && !sda_now) begin
      mon_starts++;
      mon_bitcnt  = 0;
      mon_bytecnt = 0;
    end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
      mon_stops++;
      mon_bitcnt = 0;
    end else if (!prev_scl && scl_now) begin
      if (mon_bitcnt < 8) begin
        mon_shift = {mon_shift[6:0], sda_now};
        mon_bitcnt++;
      end else begin
        mon_bytes.push_back(mon_shift);
        mon_acks.push_back(sda_now);
        mon_bitcnt = 0;
        mon_bytecnt++;
      end
    end else if (prev_scl && !scl_now) begin
      if (mon_bitcnt == 8 && mon_bytecnt < 3)
        slave_pull = ~nack_mask[mon_bytecnt];
      else if (mon_bitcnt == 0)
        slave_pull = 1'b0;
    end
    if (reset) slave_pull = 1'b0;
    prev_scl = scl_now;
    prev_sda = sda_now;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%b required=%b", name, act, exp);
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference model: what the bus and flags must show for a word and NACK mask
  function automatic int nack_idx(input logic [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return i;
    return 3;
  endfunction

  function automatic int bytes_per_attempt(input logic [2:0] m);
`ifdef I2C_CFG_RETRY_EN
    return (nack_idx(m) == 3) ? 3 : nack_idx(m) + 1;
`else
    return 3;
`endif
  endfunction

  function automatic int attempts(input logic [2:0] m);
`ifdef I2C_CFG_RETRY_EN
    return (m == 3'b000) ? 1 : 4;
`else
    return 1;
`endif
  endfunction

  function automatic int exp_latency(input logic [2:0] m);
    return attempts(m) * (2 + 36 * bytes_per_attempt(m) + 3) * QD + 1;
  endfunction

  function automatic logic ref_ack_err(input logic [2:0] m);
    return |m;
  endfunction

  task automatic run_txn(input logic [23:0] d, input logic [2:0] m, input logic exp_err,
                         input int inject_at, input string tag);
    int  s0, p0, b0, lat, nb, per, k;
    bit  done;
    s0 = mon_starts; p0 = mon_stops; b0 = mon_bytes.size();
    nack_mask = m;
    @(negedge clk);
    bus.i2c_data = d;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.i2c_data = 24'h000000;
    check1({tag, "_busy_on_accept"}, bus.busy, 1'b1);
    check1({tag, "_end_cleared"}, bus.end_flag, 1'b0);
    check1({tag, "_err_cleared"}, bus.ack_err, 1'b0);
    lat = 0; done = 0;
    while (!done && lat < C_TIMEOUT) begin
      @(negedge clk);
      lat++;
      if (lat == inject_at) begin
        bus.i2c_data = ~d;
        bus.start    = 1'b1;
      end else if (lat == inject_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.end_flag) done = 1;
    end
    check1({tag, "_completed"}, done, 1'b1);
    checkn({tag, "_latency"}, lat, exp_latency(m));
    check1({tag, "_busy_low"}, bus.busy, 1'b0);
    check1({tag, "_ack_err"}, bus.ack_err, exp_err);
    checkn({tag, "_starts"}, mon_starts - s0, attempts(m));
    checkn({tag, "_stops"}, mon_stops - p0, attempts(m));
    per = bytes_per_attempt(m);
    nb  = per * attempts(m);
    checkn({tag, "_nbytes"}, mon_bytes.size() - b0, nb);
    for (int j = 0; j < nb; j++) begin
      if (b0 + j < mon_bytes.size()) begin
        k = j % per;
        checkn({tag, "_byte"}, int'(mon_bytes[b0 + j]), int'(d[23 - 8 * k -: 8]));
        check1({tag, "_ackbit"}, mon_acks[b0 + j], m[k]);
      end
    end
    @(negedge clk);
    check1({tag, "_end_sticky"}, bus.end_flag, 1'b1);
  endtask

  typedef struct packed {
    logic [23:0] data;
    logic [2:0]  nack;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   s0, p0, b0, lat, cnt;
    bit   done;
    logic [23:0] rd;
    logic [2:0]  rm;

    vecs[0] = '{data: 24'h340E42, nack: 3'b000, exp_err: 1'b0};
    vecs[1] = '{data: 24'h340E42, nack: 3'b010, exp_err: 1'b1};
    vecs[2] = '{data: 24'h340E42, nack: 3'b000, exp_err: 1'b0};
    vecs[3] = '{data: 24'hFF00A5, nack: 3'b101, exp_err: 1'b1};
    vecs[4] = '{data: 24'h000000, nack: 3'b100, exp_err: 1'b1};

    reset = 1'b1; bus.start = 1'b1; bus.i2c_data = 24'h340E42; nack_mask = 3'b000;
    repeat (3) begin
      @(negedge clk);
      check1("rst_busy", bus.busy, 1'b0);
      check1("rst_end", bus.end_flag, 1'b0);
      check1("rst_err", bus.ack_err, 1'b0);
      check1("rst_scl", bus.i2c_sclk, 1'b1);
      check1("rst_oe", bus.i2c_sdat_oe, 1'b0);
    end
    reset = 1'b0; bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check1("post_rst_idle", bus.busy, 1'b0);
    checkn("post_rst_no_start", mon_starts, 0);

    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].data, vecs[i].nack, vecs[i].exp_err, 0, $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      rd = 24'($urandom);
      rm = 3'($urandom_range(0, 7));
      run_txn(rd, rm, ref_ack_err(rm), 0, $sformatf("rnd%0d", i));
    end

    run_txn(24'h340E42, 3'b000, 1'b0, 500, "ignore_start");

    // Reset in the middle of the register byte, while SCL is low
    s0 = mon_starts; p0 = mon_stops; b0 = mon_bytes.size();
    nack_mask = 3'b000;
    @(negedge clk); bus.i2c_data = 24'h340E42; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    lat = 0;
    while (!((mon_bytes.size() - b0) == 1 && mon_bitcnt == 4 && bus.i2c_sclk == 1'b0)
           && lat < C_TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    check1("midrst_reached", lat < C_TIMEOUT, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check1("midrst_scl", bus.i2c_sclk, 1'b1);
    check1("midrst_oe", bus.i2c_sdat_oe, 1'b0);
    check1("midrst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    repeat (4 * QD) @(negedge clk);
    check1("midrst_stays_idle", bus.busy, 1'b0);
    checkn("midrst_no_stop", mon_stops - p0, 0);
    checkn("midrst_one_start", mon_starts - s0, 1);
    run_txn(24'h1A2B3C, 3'b000, 1'b0, 0, "after_rst");

    // start held high: back-to-back transactions
    s0 = mon_starts; nack_mask = 3'b000;
    @(negedge clk); bus.i2c_data = 24'h5566AA; bus.start = 1'b1;
    @(negedge clk);
    lat = 0; done = 0;
    while (!done && lat < C_TIMEOUT) begin
      @(negedge clk);
      lat++;
      if (bus.end_flag) done = 1;
    end
    checkn("b2b_first_latency", lat, exp_latency(3'b000));
    cnt = 0; done = 0;
    while (!done && cnt < C_TIMEOUT) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check1("b2b_end_one_cycle", bus.end_flag, 1'b0);
        check1("b2b_rearm_busy", bus.busy, 1'b1);
      end else if (bus.end_flag) begin
        done = 1;
      end
    end
    bus.start = 1'b0;
    checkn("b2b_period", cnt, exp_latency(3'b000) + 1);
    @(negedge clk);
    check1("b2b_final_end", bus.end_flag, 1'b1);
    check1("b2b_final_idle", bus.busy, 1'b0);
    checkn("b2b_starts", mon_starts - s0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
